// File: rtl/cp0_pkg.sv
// CP0 shared constants: register numbers, SR/Cause bit positions, exception codes.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cp0_pkg;

  // mfc0/mtc0 register numbers
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  // SR fields
  localparam int SR_IE  = 0;
  localparam int SR_EXL = 1;
  localparam int IM_LO  = 10;
  localparam int IM_HI  = 15;

  // Cause fields; IP[15] mirrors TI
  localparam int CAUSE_BD = 31;
  localparam int CAUSE_TI = 30;
  localparam int IP_LO    = 10;
  localparam int IP_HI    = 15;
  localparam int EXC_LO   = 2;
  localparam int EXC_HI   = 6;

  // Exception codes
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Address errors are the only exceptions that capture BadVAddr
  function automatic logic is_addr_err(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with prescaler; raises TI when Count steps onto Compare.
// Latency: count/compare/ti are registered, updated on the write or tick edge.
// Backpressure: none; writes always accepted, write to Count overrides a tick.
module cp0_timer #(
  parameter int CNT_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wr_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam logic [7:0] DIV_LAST = 8'(CNT_DIV - 1);

  logic [7:0]  presc_q, presc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;
  logic        tick;
  logic [31:0] count_inc;

  assign count_inc = count_q + 32'd1;
  assign tick      = (presc_q == DIV_LAST);

  // Next-state: software load beats the prescaled increment; Compare write clears TI last
  always_comb begin
    presc_d   = presc_q;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (count_we) begin
      count_d = wr_data;
      presc_d = '0;
    end else if (tick) begin
      count_d = count_inc;
      presc_d = '0;
      if (count_inc == compare_q) ti_d = 1'b1;
    end else begin
      presc_d = presc_q + 8'd1;
    end
    if (compare_we) begin
      compare_d = wr_data;
      ti_d      = 1'b0;
    end
  end

  // Timer state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;

endmodule

// File: rtl/cp0_ext.sv
// CP0 with external level/edge interrupts, Count/Compare timer and BadVAddr.
// Latency: req, epc_out, dout combinational; register updates on next posedge.
// Backpressure: none; an mtc0 coinciding with req is dropped.
module cp0_ext
  import cp0_pkg::*;
#(
  parameter int          N_HWINT   = 5,
  parameter logic [4:0]  EDGE_MASK = 5'b0,
  parameter int          CNT_DIV   = 1,
  parameter logic [31:0] PRID      = 32'h2002_0907
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         rd_addr,
  input  logic [4:0]         wr_addr,
  input  logic [31:0]        wr_data,
  input  logic               we,
  input  logic [29:0]        pc,
  input  logic               in_delay_slot,
  input  logic [4:0]         exc_code_in,
  input  logic [31:0]        bad_vaddr_in,
  input  logic [N_HWINT-1:0] hw_int,
  input  logic               exl_clr,
  output logic               req,
  output logic [31:0]        epc_out,
  output logic [31:0]        dout,
  output logic               timer_int
);

  logic [5:0]         im_q, im_d;
  logic               exl_q, exl_d;
  logic               ie_q, ie_d;
  logic               bd_q, bd_d;
  logic [4:0]         exc_q, exc_d;
  logic [29:0]        epc_q, epc_d;
  logic [31:0]        bad_q, bad_d;
  logic [N_HWINT-1:0] ipl_q, ipl_d;
  logic [N_HWINT-1:0] prev_q;

  logic [31:0] count, compare;
  logic        ti;
  logic [5:0]  ip_all;
  logic        int_req, exc_req, wr_ok;
  logic [29:0] epc_new;

  // Full IP[15:10] view: TI on top, unused lines read 0
  always_comb begin
    ip_all            = '0;
    ip_all[N_HWINT-1:0] = ipl_q;
    ip_all[5]         = ti;
  end

  // Reset forces req low so nothing is taken while the core is held
  assign int_req = ~reset & ~exl_q & ie_q & (|(ip_all & im_q));
  assign exc_req = ~reset & ~exl_q & (exc_code_in != EXC_INT);
  assign req     = int_req | exc_req;
  assign wr_ok   = we & ~req;
  assign epc_new = in_delay_slot ? (pc - 30'd1) : pc;
  assign epc_out = {(req ? epc_new : epc_q), 2'b00};

  cp0_timer #(.CNT_DIV(CNT_DIV)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (wr_ok && (wr_addr == REG_COUNT)),
    .compare_we (wr_ok && (wr_addr == REG_COMPARE)),
    .wr_data    (wr_data),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );
  assign timer_int = ti;

  // Interrupt pending: level lines track input, edge lines latch rising edges until cleared by software
  always_comb begin
    ipl_d = ipl_q;
    for (int i = 0; i < N_HWINT; i++) begin
      if (EDGE_MASK[i]) begin
        ipl_d[i] = (hw_int[i] & ~prev_q[i]) |
                   (ipl_q[i] & ~(wr_ok && (wr_addr == REG_CAUSE) && !wr_data[IP_LO + i]));
      end else begin
        ipl_d[i] = hw_int[i];
      end
    end
  end

  // SR/Cause/EPC/BadVAddr next-state: mtc0, then eret, then exception entry wins
  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    epc_d = epc_q;
    bad_d = bad_q;
    if (wr_ok && (wr_addr == REG_SR)) begin
      im_d  = wr_data[IM_HI:IM_LO];
      exl_d = wr_data[SR_EXL];
      ie_d  = wr_data[SR_IE];
    end
    if (exl_clr) exl_d = 1'b0;
    if (req) begin
      exl_d = 1'b1;
      bd_d  = in_delay_slot;
      exc_d = int_req ? EXC_INT : exc_code_in;
      epc_d = epc_new;
      if (!int_req && is_addr_err(exc_code_in)) bad_d = bad_vaddr_in;
    end
  end

  // Architectural state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q   <= '0;
      exl_q  <= 1'b0;
      ie_q   <= 1'b0;
      bd_q   <= 1'b0;
      exc_q  <= '0;
      epc_q  <= '0;
      bad_q  <= '0;
      ipl_q  <= '0;
      prev_q <= '0;
    end else begin
      im_q   <= im_d;
      exl_q  <= exl_d;
      ie_q   <= ie_d;
      bd_q   <= bd_d;
      exc_q  <= exc_d;
      epc_q  <= epc_d;
      bad_q  <= bad_d;
      ipl_q  <= ipl_d;
      prev_q <= hw_int;
    end
  end

  // mfc0 read mux
  always_comb begin
    dout = '0;
    case (rd_addr)
      REG_BADVADDR: dout = bad_q;
      REG_COUNT:    dout = count;
      REG_COMPARE:  dout = compare;
      REG_SR:       dout = {16'h0, im_q, 8'h0, exl_q, ie_q};
      REG_CAUSE:    dout = {bd_q, ti, 14'h0, ip_all, 3'h0, exc_q, 2'b00};
      REG_EPC:      dout = epc_out;
      REG_PRID:     dout = PRID;
      default:      dout = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_ext.sv
module tb_cp0_ext;

  localparam int         NH   = 5;
  localparam logic [4:0] EDGE = 5'b00010;
  localparam int         DIV  = 2;

  logic          clk, reset;
  logic [4:0]    rd_addr, wr_addr, exc_code_in;
  logic [31:0]   wr_data, bad_vaddr_in;
  logic          we, in_delay_slot, exl_clr;
  logic [29:0]   pc;
  logic [NH-1:0] hw_int;
  logic          req, timer_int;
  logic [31:0]   epc_out, dout;

  cp0_ext #(.N_HWINT(NH), .EDGE_MASK(EDGE), .CNT_DIV(DIV), .PRID(32'h2002_0907)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .wr_addr(wr_addr), .wr_data(wr_data),
    .we(we), .pc(pc), .in_delay_slot(in_delay_slot), .exc_code_in(exc_code_in),
    .bad_vaddr_in(bad_vaddr_in), .hw_int(hw_int), .exl_clr(exl_clr),
    .req(req), .epc_out(epc_out), .dout(dout), .timer_int(timer_int)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [5:0]    m_im;
  bit          m_exl, m_ie, m_bd, m_ti;
  bit [4:0]    m_exc;
  bit [29:0]   m_epc;
  bit [31:0]   m_bad, m_count, m_compare;
  int          m_phase;            // cycles elapsed since Count last moved or was loaded
  bit [NH-1:0] m_ipl, m_prev;

  task automatic model_reset();
    m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_exc = 0; m_epc = 0;
    m_bad = 0; m_count = 0; m_compare = 0; m_phase = 0; m_ipl = 0; m_prev = 0;
  endtask

  function automatic bit m_irq();
    return !reset && !m_exl && m_ie && (({m_ti, m_ipl} & m_im) != 6'd0);
  endfunction

  function automatic bit m_req();
    return m_irq() || (!reset && !m_exl && exc_code_in != 5'd0);
  endfunction

  function automatic bit [29:0] m_target();
    return in_delay_slot ? pc - 30'd1 : pc;
  endfunction

  function automatic bit [31:0] m_epc_out();
    return {(m_req() ? m_target() : m_epc), 2'b00};
  endfunction

  function automatic bit [31:0] m_dout();
    case (rd_addr)
      5'd8:    return m_bad;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return {16'h0, m_im, 8'h0, m_exl, m_ie};
      5'd13:   return {m_bd, m_ti, 14'h0, m_ti, m_ipl, 3'h0, m_exc, 2'b00};
      5'd14:   return m_epc_out();
      5'd15:   return 32'h2002_0907;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    bit ir, r, w;
    bit [31:0] nc;
    ir = m_irq();
    r  = m_req();
    w  = we && !r;
    // timer
    if (w && wr_addr == 5'd9) begin
      m_count = wr_data; m_phase = 0;
    end else if (m_phase == DIV - 1) begin
      nc = m_count + 1;
      if (nc == m_compare) m_ti = 1;
      m_count = nc; m_phase = 0;
    end else begin
      m_phase++;
    end
    if (w && wr_addr == 5'd11) begin
      m_compare = wr_data; m_ti = 0;
    end
    // interrupt lines
    for (int i = 0; i < NH; i++) begin
      if (EDGE[i]) begin
        if (hw_int[i] && !m_prev[i]) m_ipl[i] = 1;
        else if (w && wr_addr == 5'd13 && !wr_data[10 + i]) m_ipl[i] = 0;
      end else begin
        m_ipl[i] = hw_int[i];
      end
    end
    m_prev = hw_int;
    // status / exception entry
    if (w && wr_addr == 5'd12) begin
      m_im = wr_data[15:10]; m_exl = wr_data[1]; m_ie = wr_data[0];
    end
    if (exl_clr) m_exl = 0;
    if (r) begin
      m_exl = 1;
      m_bd  = in_delay_slot;
      m_exc = ir ? 5'd0 : exc_code_in;
      m_epc = m_target();
      if (!ir && (exc_code_in == 5'd4 || exc_code_in == 5'd5)) m_bad = bad_vaddr_in;
    end
  endtask

  always @(posedge clk) begin
    if (reset) model_reset();
    else model_step();
  end

  // Compare process: all outputs every cycle, away from the active edge
  always @(negedge clk) begin
    if (reset) model_reset();
    check("req", {31'h0, req}, {31'h0, m_req()});
    check("epc_out", epc_out, m_epc_out());
    check("dout", dout, m_dout());
    check("timer_int", {31'h0, timer_int}, {31'h0, m_ti});
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; exc_code_in = 0; exl_clr = 0; in_delay_slot = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1; wr_addr = a; wr_data = d;
    step(1);
    we = 0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    rd_addr = a;
    #1;
    v = dout;
  endtask

  logic [4:0] waddrs [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
  logic [4:0] codes  [4] = '{5'd4, 5'd5, 5'd10, 5'd12};

  task automatic random_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      we = ($urandom_range(0, 3) == 0);
      wr_addr = waddrs[$urandom_range(0, 7)];
      wr_data = $urandom;
      if ((wr_addr == 5'd9 || wr_addr == 5'd11) && $urandom_range(0, 1) == 1)
        wr_data = $urandom_range(0, 20);
      rd_addr = ($urandom_range(0, 1) == 1) ? waddrs[$urandom_range(0, 7)] : 5'($urandom_range(0, 31));
      exc_code_in = ($urandom_range(0, 7) == 0) ? codes[$urandom_range(0, 3)] : 5'd0;
      pc = 30'($urandom);
      in_delay_slot = 1'($urandom_range(0, 1));
      bad_vaddr_in = $urandom;
      exl_clr = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) hw_int[$urandom_range(0, NH - 1)] ^= 1'b1;
      step(1);
    end
  endtask

  logic [31:0] v;

  initial begin
    clk = 0; reset = 1;
    rd_addr = 0; wr_addr = 0; wr_data = 0; we = 0; pc = 0; in_delay_slot = 0;
    exc_code_in = 0; bad_vaddr_in = 0; hw_int = 0; exl_clr = 0;
    step(2);
    reset = 0;
    rd(15, v); check("prid_reset", v, 32'h2002_0907);
    rd(12, v); check("sr_reset", v, 32'h0);
    check("req_reset", {31'h0, req}, 32'h0);
    step(1);

    // Level interrupt on line 0
    mtc0(12, 32'h0000_0401);
    hw_int = 5'b00001; pc = 30'h100;
    step(1);
    #1;
    check("lvl_req", {31'h0, req}, 32'h1);
    check("lvl_epc_fwd", epc_out, 32'h0000_0400);
    hw_int = 0;
    step(1);
    check("lvl_req_drop", {31'h0, req}, 32'h0);
    rd(12, v); check("lvl_sr_exl", v, 32'h0000_0403);
    rd(13, v); check("lvl_exccode", {27'h0, v[6:2]}, 32'h0);
    rd(14, v); check("lvl_epc", v, 32'h0000_0400);
    exl_clr = 1; step(1); exl_clr = 0;
    mtc0(12, 32'h0);

    // Address-error load in a delay slot
    pc = 30'hC01; in_delay_slot = 1; exc_code_in = 5'd4; bad_vaddr_in = 32'h3005;
    #1;
    check("adel_req", {31'h0, req}, 32'h1);
    check("adel_epc_fwd", epc_out, 32'h0000_3000);
    step(1);
    idle();
    rd(8, v);  check("adel_badvaddr", v, 32'h0000_3005);
    rd(13, v); check("adel_bd", {31'h0, v[31]}, 32'h1);
               check("adel_exccode", {27'h0, v[6:2]}, 32'h4);
    exl_clr = 1; step(1); exl_clr = 0;

    // Timer with prescaler of 2
    mtc0(11, 32'd3);
    mtc0(9, 32'd0);
    step(5);
    check("timer_early", {31'h0, timer_int}, 32'h0);
    step(1);
    check("timer_hit", {31'h0, timer_int}, 32'h1);
    mtc0(12, 32'h0000_8001);
    #1;
    check("timer_req", {31'h0, req}, 32'h1);
    step(1);
    mtc0(11, 32'd10);
    check("timer_clear", {31'h0, timer_int}, 32'h0);
    mtc0(12, 32'h0);

    // Edge line 1: pulse latches, set beats simultaneous clear
    hw_int = 5'b00010; step(1); hw_int = 0; step(3);
    rd(13, v); check("edge_latched", {31'h0, v[11]}, 32'h1);
    hw_int = 5'b00010; we = 1; wr_addr = 5'd13; wr_data = 32'h0;
    step(1);
    we = 0;
    rd(13, v); check("edge_set_wins", {31'h0, v[11]}, 32'h1);
    hw_int = 0;
    mtc0(13, 32'h0);
    rd(13, v); check("edge_cleared", {31'h0, v[11]}, 32'h0);

    // mtc0 dropped when it coincides with req; eret re-raises pending interrupt
    mtc0(12, 32'h0000_0401);
    hw_int = 5'b00001;
    step(1);
    check("drop_req", {31'h0, req}, 32'h1);
    we = 1; wr_addr = 5'd12; wr_data = 32'h0;
    step(1);
    we = 0;
    rd(12, v); check("drop_sr", v, 32'h0000_0403);
    exl_clr = 1; step(1); exl_clr = 0;
    #1;
    check("eret_rereq", {31'h0, req}, 32'h1);
    hw_int = 0;
    step(2);
    mtc0(12, 32'h0);

    random_cycles(3000);

    // Mid-run reset
    idle(); hw_int = 0;
    step(2);
    mtc0(12, 32'h0);
    mtc0(12, 32'h0);
    mtc0(9, 32'h1234);
    exc_code_in = 5'd10;
    step(1);
    reset = 1;
    #1;
    check("rst_req", {31'h0, req}, 32'h0);
    rd(9, v);  check("rst_count", v, 32'h0);
    rd(15, v); check("rst_prid", v, 32'h2002_0907);
    step(1);
    reset = 0; idle();
    step(1);

    random_cycles(1500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
